// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_ctrl_pkg : shared types for the MIPS hazard/stall controller  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         ENTRY_W  = 6;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
  } sb_entry_t;

  function automatic logic entry_hit(input sb_entry_t e, input logic [4:0] r);
    return e.valid && (e.dest == r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_dest_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dest_scoreboard : in-flight destination tracker (EX, MEM, optional WB)     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dest_scoreboard
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int WB_CHECK = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       kill_i,
  input  sb_entry_t  entry_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  output logic       rs_match_o,
  output logic       rt_match_o
);

  sb_entry_t ex_q, ex_d, mem_q;
  logic      wb_rs_hit, wb_rt_hit;

  // A stalled or squashed ID instruction enters EX as a bubble.
  assign ex_d = kill_i ? '0 : entry_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
    end
  end

  generate
    if (WB_CHECK != 0) begin : g_wb
      sb_entry_t wb_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wb_q <= '0;
        else         wb_q <= mem_q;
      end
      assign wb_rs_hit = entry_hit(wb_q, rs_i);
      assign wb_rt_hit = entry_hit(wb_q, rt_i);
    end else begin : g_no_wb
      assign wb_rs_hit = 1'b0;
      assign wb_rt_hit = 1'b0;
    end
  endgenerate

  assign rs_match_o = entry_hit(ex_q, rs_i) | entry_hit(mem_q, rs_i) | wb_rs_hit;
  assign rt_match_o = entry_hit(ex_q, rt_i) | entry_hit(mem_q, rt_i) | wb_rt_hit;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_ctrl : RAW stall / branch flush control, no-forwarding MIPS   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int WB_CHECK = 0,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Valid_ID,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic [4:0]       Rd_ID,
  input  logic             UsesRs_ID,
  input  logic             UsesRt_ID,
  input  logic             RegWrite_ID,
  input  logic             RegDst_ID,
  input  logic             BranchTaken_EX,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCycles
);

  logic [4:0] dest_id;
  sb_entry_t  new_entry;
  logic       rs_match, rt_match;
  logic       hazard, stall;
  state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign dest_id         = RegDst_ID ? Rd_ID : Rt_ID;
  assign new_entry.valid = Valid_ID & RegWrite_ID & (dest_id != REG_ZERO);
  assign new_entry.dest  = dest_id;

  dest_scoreboard #(
    .WB_CHECK(WB_CHECK)
  ) u_sb (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .kill_i     (stall | BranchTaken_EX),
    .entry_i    (new_entry),
    .rs_i       (Rs_ID),
    .rt_i       (Rt_ID),
    .rs_match_o (rs_match),
    .rt_match_o (rt_match)
  );

  assign hazard = Valid_ID & ((UsesRs_ID & (Rs_ID != REG_ZERO) & rs_match) |
                              (UsesRt_ID & (Rt_ID != REG_ZERO) & rt_match));
  assign stall  = hazard & ~BranchTaken_EX;

  // State is a trace aid only; none of the pipeline controls read it.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    state_d    = ST_RUN;
    if (BranchTaken_EX) begin
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      state_d    = ST_FLUSH;
    end else if (stall) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      state_d    = ST_STALL;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  assign cnt_d = (stall && (cnt_q != {CNT_W{1'b1}})) ?
                 cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign State       = state_q;
  assign StallCycles = cnt_q;

endmodule
`default_nettype wire
